// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI front-end.
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE,
        XFER1,
        GAP,
        XFER2,
        DONE
    } a2d_state_t;

    localparam logic [10:0] A2D_CMD_PAD    = 11'h000;
    localparam int          A2D_SCLK_DIV_W = 5;

    // Channel command word: two zero bits, channel, zero padding.
    function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
        return {2'b00, ch, A2D_CMD_PAD};
    endfunction

endpackage

// File: rtl/a2d_intf_spi.sv
// 16-bit SPI master: SCLK divider, bit counter, shifter and SS_n/SCLK/MOSI registers.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = A2D_SCLK_DIV_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    logic                  busy_q;
    logic                  ss_n_q;
    logic [SCLK_DIV_W-1:0] div_q;
    logic [3:0]            bit_cnt_q;
    logic [15:0]           shreg_q;
    logic                  shift;

    // Shift on the last divider count, which is the edge where SCLK rises.
    assign shift   = busy_q && (&div_q);
    // done marks the cycle of the final shift; rd_data is the word completed on that edge.
    assign done    = shift && (&bit_cnt_q);
    assign rd_data = {shreg_q[14:0], MISO};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= 1'b0;
            ss_n_q    <= 1'b1;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
        end else if (wrt && !busy_q) begin
            busy_q    <= 1'b1;
            ss_n_q    <= 1'b0;
            div_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= cmd;
        end else if (busy_q) begin
            div_q <= div_q + 1'b1;
            if (shift) begin
                shreg_q   <= {shreg_q[14:0], MISO};
                bit_cnt_q <= bit_cnt_q + 1'b1;
                if (done) begin
                    busy_q <= 1'b0;
                    ss_n_q <= 1'b1;
                end
            end
        end
    end

    // The divider wraps to zero after the final shift, so SCLK idles high.
    assign SS_n = ss_n_q;
    assign SCLK = ~div_q[SCLK_DIV_W-1];
    assign MOSI = shreg_q[15];

endmodule

// File: rtl/a2d_intf.sv
// A2D conversion sequencer: command transfer, SS_n gap, read transfer, result pulse.
// Define A2D_INVERT_EN to store the inverted conversion in res.
module a2d_intf
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = A2D_SCLK_DIV_W,
    parameter int GAP_CLKS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int GAP_W = $clog2(GAP_CLKS) + 1;

    a2d_state_t       state_q, state_d;
    logic [2:0]       chnnl_q, chnnl_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [11:0]      res_q, res_d;
    logic             cnv_cmplt_q, cnv_cmplt_d;

    logic             spi_wrt;
    logic             spi_done;
    logic [15:0]      spi_cmd;
    logic [15:0]      spi_rd_data;
    logic [11:0]      rx_res;
    logic             unused_rd_hi;

`ifdef A2D_INVERT_EN
    assign rx_res = ~spi_rd_data[11:0];
`else
    assign rx_res = spi_rd_data[11:0];
`endif
    assign unused_rd_hi = ^spi_rd_data[15:12];

    always_comb begin
        state_d     = state_q;
        chnnl_d     = chnnl_q;
        gap_cnt_d   = '0;
        res_d       = res_q;
        cnv_cmplt_d = 1'b0;
        spi_wrt     = 1'b0;
        spi_cmd     = a2d_cmd(chnnl_q);
        case (state_q)
            IDLE: begin
                // The live channel feeds the first command so SS_n can fall on the next edge.
                if (strt_cnv) begin
                    chnnl_d = chnnl;
                    spi_cmd = a2d_cmd(chnnl);
                    spi_wrt = 1'b1;
                    state_d = XFER1;
                end
            end
            XFER1: begin
                if (spi_done) state_d = GAP;
            end
            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CLKS - 1)) begin
                    spi_wrt = 1'b1;
                    state_d = XFER2;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            XFER2: begin
                if (spi_done) begin
                    res_d       = rx_res;
                    cnv_cmplt_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            chnnl_q     <= '0;
            gap_cnt_q   <= '0;
            res_q       <= '0;
            cnv_cmplt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            chnnl_q     <= chnnl_d;
            gap_cnt_q   <= gap_cnt_d;
            res_q       <= res_d;
            cnv_cmplt_q <= cnv_cmplt_d;
        end
    end

    spi_mstr16 #(
        .SCLK_DIV_W(SCLK_DIV_W)
    ) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (spi_wrt),
        .cmd     (spi_cmd),
        .done    (spi_done),
        .rd_data (spi_rd_data),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO)
    );

    assign cnv_cmplt = cnv_cmplt_q;
    assign res       = res_q;

endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf with an SPI A2D slave model and randomized conversions.
module tb_a2d_intf;

    logic        clk = 1'b0;
    logic        rst;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        MISO;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;

    a2d_intf dut (
        .clk       (clk),
        .rst       (rst),
        .strt_cnv  (strt_cnv),
        .chnnl     (chnnl),
        .cnv_cmplt (cnv_cmplt),
        .res       (res),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] res;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [11:0] adc_val [8];
    logic [11:0] last_res = 12'h000;

    always @(posedge clk) cyc <= cyc + 1;

    // Channel wanders after the start cycle; the DUT must ignore it.
    always @(posedge clk) begin
        #2;
        if (!strt_cnv) chnnl = 3'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    function automatic logic [11:0] model_res(input logic [2:0] ch);
`ifdef A2D_INVERT_EN
        return ~adc_val[ch];
`else
        return adc_val[ch];
`endif
    endfunction

    task automatic start(input logic [2:0] ch);
        exp_t e;
        @(posedge clk); #1;
        strt_cnv = 1'b1;
        chnnl    = ch;
        e.ch  = ch;
        e.res = model_res(ch);
        e.cyc = cyc + 1057;
        exp_q.push_back(e);
        @(posedge clk); #1;
        strt_cnv = 1'b0;
    endtask

    task automatic wait_cmplt(input int limit);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cnv_cmplt && n < limit);
        chk("cmplt_arrival", {31'd0, cnv_cmplt}, 32'd1);
    endtask

    // A2D slave model plus monitor: captures MOSI at SCLK rises, drives MISO at falls.
    logic        sclk_prev = 1'b1;
    logic        ssn_prev  = 1'b1;
    logic        mosi_hold = 1'b0;
    logic [15:0] mosi_word = 16'h0;
    logic [15:0] miso_word = 16'h0;
    logic [2:0]  ch_seen   = 3'd0;
    int          xfer_idx  = 0;
    int          bit_idx   = 0;
    int          rx_cnt    = 0;
    int          fall_cyc  = 0;

    always @(negedge clk) begin
        if (rst) begin
            xfer_idx  = 0;
            rx_cnt    = 0;
            bit_idx   = 0;
            sclk_prev = 1'b1;
            ssn_prev  = 1'b1;
            exp_q.delete();
        end else begin
            if (ssn_prev && !SS_n) begin
                fall_cyc  = cyc;
                bit_idx   = 0;
                rx_cnt    = 0;
                mosi_word = 16'h0;
                if (exp_q.size() == 0) begin
                    chk("xfer_without_start", 32'd1, 32'd0);
                end else begin
                    chk("ss_fall_cycle", cyc,
                        (xfer_idx == 0) ? exp_q[0].cyc - 1056 : exp_q[0].cyc - 512);
                end
                if (xfer_idx == 0) miso_word = 16'($urandom);
                else               miso_word = {4'($urandom), adc_val[ch_seen]};
            end
            if (sclk_prev && !SCLK && bit_idx < 16) begin
                MISO = miso_word[15 - bit_idx];
                bit_idx++;
            end
            if (!sclk_prev && SCLK) begin
                mosi_word = {mosi_word[14:0], mosi_hold};
                rx_cnt++;
                if (rx_cnt == 16) begin
                    if (exp_q.size() != 0)
                        chk("mosi_cmd", {16'd0, mosi_word}, 32'(exp_q[0].ch) << 11);
                    if (xfer_idx == 0) ch_seen = mosi_word[13:11];
                end
            end
            if (!ssn_prev && SS_n) begin
                chk("ss_low_len", cyc - fall_cyc, 32'd512);
                chk("sclk_high_at_ss_rise", {31'd0, SCLK}, 32'd1);
                xfer_idx++;
            end
            if (cnv_cmplt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmplt", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("conv ch=%0d res=%h expect=%h cycle=%0d", e.ch, res, e.res, cyc);
                    chk("res", {20'd0, res}, {20'd0, e.res});
                    chk("cmplt_cycle", cyc, e.cyc);
                    chk("xfers_per_conv", xfer_idx, 32'd2);
                    last_res = e.res;
                end
                xfer_idx = 0;
            end
            if (!SCLK) mosi_hold = MOSI;
            sclk_prev = SCLK;
            ssn_prev  = SS_n;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] seq [6];
        seq = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
        rst      = 1'b1;
        strt_cnv = 1'b0;
        chnnl    = 3'd0;
        MISO     = 1'b0;
        foreach (adc_val[i]) adc_val[i] = 12'($urandom);

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clk);
            chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
            chk("rst_sclk", {31'd0, SCLK}, 32'd1);
            chk("rst_mosi", {31'd0, MOSI}, 32'd0);
            chk("rst_res", {20'd0, res}, 32'd0);
            chk("rst_cmplt", {31'd0, cnv_cmplt}, 32'd0);
        end

        // Channel 5 command, then a fixed result held over a long idle
        adc_val[5] = 12'hA5C;
        start(3'd5);
        wait_cmplt(1200);
        repeat (2000) @(negedge clk);
        chk("res_held", {20'd0, res}, {20'd0, model_res(3'd5)});

        // Start request during a conversion is ignored
        start(3'd1);
        repeat (299) @(posedge clk);
        #1 strt_cnv = 1'b1;
        chnnl = 3'd2;
        @(posedge clk);
        #1 strt_cnv = 1'b0;
        wait_cmplt(1200);
        repeat (1200) @(negedge clk);

        // Reset inside the read transfer aborts the conversion
        start(3'($urandom));
        repeat (699) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_res", {20'd0, res}, 32'd0);
        chk("abort_ss_n", {31'd0, SS_n}, 32'd1);
        chk("abort_sclk", {31'd0, SCLK}, 32'd1);
        repeat (1200) @(negedge clk);
        adc_val[6] = 12'h123;
        start(3'd6);
        wait_cmplt(1200);

        // Back-to-back sequence; the first start pulse overlaps each cnv_cmplt cycle
        foreach (adc_val[i]) adc_val[i] = 12'($urandom);
        start(seq[0]);
        for (int i = 1; i < 6; i++) begin
            wait_cmplt(1200);
            strt_cnv = 1'b1;
            start(seq[i]);
        end
        wait_cmplt(1200);

        // Random channels, values and idle gaps
        for (int i = 0; i < 4; i++) begin
            foreach (adc_val[k]) adc_val[k] = 12'($urandom);
            repeat ($urandom_range(0, 50)) @(posedge clk);
            start(3'($urandom));
            wait_cmplt(1200);
        end

        repeat (20) @(negedge clk);
        chk("final_res", {20'd0, res}, {20'd0, last_res});
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
